// File: rtl/halfband_interp_poly.sv
// Polyphase half-band interpolator (x2): one time-shared multiplier walks the
// even-phase taps, then the odd-phase taps, emitting two samples per input.
module halfband_interp_poly #(
    parameter int HB_TAPS    = 31,
    parameter int DATA_WIDTH = 24,
    parameter int COEF_WIDTH = 24,
    parameter int COEF_FRAC  = 23,
    parameter int OUT_WIDTH  = 24,
    // Packed tap tables, entry k at bits [k*COEF_WIDTH +: COEF_WIDTH].
    parameter logic [COEF_WIDTH*((HB_TAPS+1)/2)-1:0] H0_COEFS = {
        24'hFFC85C, 24'h00681B, 24'hFF23D5, 24'h01CD15,
        24'hFC93B7, 24'h064649, 24'hF39CA5, 24'h28557B,
        24'h28557B, 24'hF39CA5, 24'h064649, 24'hFC93B7,
        24'h01CD15, 24'hFF23D5, 24'h00681B, 24'hFFC85C},
    parameter logic [COEF_WIDTH*((HB_TAPS-1)/2)-1:0] H1_COEFS = {
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h400000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [OUT_WIDTH-1:0]  data_out,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam int L          = (HB_TAPS - 1) / 2;
    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(L + 2) + 2;
    localparam int KW         = (L > 1) ? $clog2(L + 1) : 1;

    localparam logic [KW-1:0] K_LAST_E = KW'(L);
    localparam logic [KW-1:0] K_LAST_O = KW'(L - 1);

    localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(64'sd1 <<< (COEF_FRAC - 2));
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX    = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN    = ~OUT_MAX;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] MAC_E  = 3'd1;
    localparam logic [2:0] EMIT_E = 3'd2;
    localparam logic [2:0] MAC_O  = 3'd3;
    localparam logic [2:0] EMIT_O = 3'd4;

    logic [2:0]                   state_reg;
    logic [KW-1:0]                k_reg;
    logic signed [ACC_WIDTH-1:0]  acc_reg;
    logic signed [DATA_WIDTH-1:0] xbuf_reg [0:L];
    logic signed [OUT_WIDTH-1:0]  data_out_reg;
    logic                         out_valid_reg;

    logic signed [COEF_WIDTH-1:0] coef_h0 [0:L];
    logic signed [COEF_WIDTH-1:0] coef_h1 [0:L];

    // The odd table is one entry shorter; pad it so both share the k index.
    genvar gi;
    generate
        for (gi = 0; gi <= L; gi++) begin : g_coef
            assign coef_h0[gi] = H0_COEFS[gi*COEF_WIDTH +: COEF_WIDTH];
            if (gi < L) begin : g_h1
                assign coef_h1[gi] = H1_COEFS[gi*COEF_WIDTH +: COEF_WIDTH];
            end else begin : g_h1_pad
                assign coef_h1[gi] = '0;
            end
        end
    endgenerate

    logic                         accept;
    logic signed [DATA_WIDTH-1:0] x_sel;
    logic signed [COEF_WIDTH-1:0] c_sel;
    logic signed [PROD_WIDTH-1:0] x_ext;
    logic signed [PROD_WIDTH-1:0] c_ext;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [ACC_WIDTH-1:0]  rounded;
    logic signed [OUT_WIDTH-1:0]  fmt_val;

    assign in_ready  = (state_reg == IDLE);
    assign accept    = in_ready && in_valid;
    assign data_out  = data_out_reg;
    assign out_valid = out_valid_reg;

    always_comb begin
        x_sel = xbuf_reg[k_reg];
        c_sel = (state_reg == MAC_O) ? coef_h1[k_reg] : coef_h0[k_reg];
    end

    assign x_ext   = PROD_WIDTH'(x_sel);
    assign c_ext   = PROD_WIDTH'(c_sel);
    assign product = x_ext * c_ext;
    assign acc_sum = acc_reg + ACC_WIDTH'(product);

    // Shift by one bit less than the coefficient scale to apply the x2 gain.
    always_comb begin
        rounded = (acc_sum + ROUND_BIAS) >>> (COEF_FRAC - 1);
        if (rounded > OUT_MAX) begin
            fmt_val = OUT_MAX[OUT_WIDTH-1:0];
        end else if (rounded < OUT_MIN) begin
            fmt_val = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            fmt_val = rounded[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= L; i++) begin
                xbuf_reg[i] <= '0;
            end
        end else if (accept) begin
            xbuf_reg[0] <= data_in;
            for (int i = 1; i <= L; i++) begin
                xbuf_reg[i] <= xbuf_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            acc_reg       <= '0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        acc_reg   <= '0;
                        k_reg     <= '0;
                        state_reg <= MAC_E;
                    end
                end
                MAC_E: begin
                    acc_reg <= acc_sum;
                    if (k_reg == K_LAST_E) begin
                        data_out_reg  <= fmt_val;
                        out_valid_reg <= 1'b1;
                        state_reg     <= EMIT_E;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                EMIT_E: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        acc_reg       <= '0;
                        k_reg         <= '0;
                        state_reg     <= MAC_O;
                    end
                end
                MAC_O: begin
                    acc_reg <= acc_sum;
                    if (k_reg == K_LAST_O) begin
                        data_out_reg  <= fmt_val;
                        out_valid_reg <= 1'b1;
                        state_reg     <= EMIT_O;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                EMIT_O: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_halfband_interp_poly.sv
// Directed bench: five coefficient variants run in lockstep on shared stimulus;
// instance 4 (default taps) is checked against a bit-exact arithmetic model.
module tb_halfband_interp_poly;
    localparam logic signed [23:0] JUNK = 24'h5A5A5A;

    logic clk = 1'b0;
    logic rst_n;
    logic signed [23:0] data_in;
    logic in_valid;
    logic out_ready;

    logic signed [23:0] dout [5];
    logic ov [5];
    logic ir [5];

    int errors = 0;
    int checks = 0;
    longint now_cyc = 0;
    longint last_acc = 0;

    logic signed [23:0] ev [5];
    logic signed [23:0] od [5];
    logic signed [23:0] hist [16];

    logic signed [23:0] h0_tab [16] = '{
        24'hFFC85C, 24'h00681B, 24'hFF23D5, 24'h01CD15,
        24'hFC93B7, 24'h064649, 24'hF39CA5, 24'h28557B,
        24'h28557B, 24'hF39CA5, 24'h064649, 24'hFC93B7,
        24'h01CD15, 24'hFF23D5, 24'h00681B, 24'hFFC85C};
    logic signed [23:0] h1_tab [15] = '{
        24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h400000,
        24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};

    always #5 clk = ~clk;

    // 0: impulse H0[0]=0.5,H1[0]=0.25  1: H0[1]=0.5  2: H0[0]=0.25  3: H0[0]=max  4: default
    halfband_interp_poly #(.H0_COEFS(384'h400000), .H1_COEFS(360'h200000)) u_imp (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(ir[0]),
        .data_out(dout[0]), .out_valid(ov[0]), .out_ready(out_ready));
    halfband_interp_poly #(.H0_COEFS(384'h400000 << 24), .H1_COEFS(360'h0)) u_imp2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(ir[1]),
        .data_out(dout[1]), .out_valid(ov[1]), .out_ready(out_ready));
    halfband_interp_poly #(.H0_COEFS(384'h200000), .H1_COEFS(360'h0)) u_rnd (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(ir[2]),
        .data_out(dout[2]), .out_valid(ov[2]), .out_ready(out_ready));
    halfband_interp_poly #(.H0_COEFS(384'h7FFFFF), .H1_COEFS(360'h0)) u_sat (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(ir[3]),
        .data_out(dout[3]), .out_valid(ov[3]), .out_ready(out_ready));
    halfband_interp_poly u_real (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(ir[4]),
        .data_out(dout[4]), .out_valid(ov[4]), .out_ready(out_ready));

    task automatic tick();
        @(posedge clk);
        #1;
        now_cyc++;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint fmt(input longint a);
        longint r;
        r = (a + 64'sd2097152) >>> 22;
        if (r > 64'sd8388607) r = 64'sd8388607;
        else if (r < -64'sd8388608) r = -64'sd8388608;
        return r;
    endfunction

    // One input sample through both output phases; checks timing and the model.
    task automatic xact(input logic signed [23:0] x, input int stall,
                        input bit keep_valid, input bit chk_gap);
        int n;
        bit stable;
        longint acc_e;
        longint acc_o;
        n = 0;
        while (!ir[0] && n < 200) begin tick(); n++; end
        data_in  = x;
        in_valid = 1'b1;
        tick();
        if (chk_gap) chk("accept_gap", now_cyc - last_acc, 34);
        last_acc = now_cyc;
        in_valid = keep_valid;
        data_in  = keep_valid ? JUNK : 24'sd0;
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;

        n = 0;
        while (!ov[0] && n < 200) begin tick(); n++; end
        chk("lat_even", n, 16);
        for (int i = 0; i < 5; i++) ev[i] = dout[i];

        if (stall > 0) begin
            out_ready = 1'b0;
            stable = 1'b1;
            for (int s = 0; s < stall; s++) begin
                tick();
                n++;
                if (dout[4] !== ev[4] || ov[4] !== 1'b1 || ir[4] !== 1'b0) stable = 1'b0;
            end
            chk("bp_stable", longint'(stable), 1);
            out_ready = 1'b1;
        end

        do begin tick(); n++; end while (!ov[0] && n < 300);
        chk("lat_odd", n, 32 + stall);
        for (int i = 0; i < 5; i++) od[i] = dout[i];
        while (!ir[0] && n < 400) begin tick(); n++; end
        chk("lat_idle", n, 33 + stall);
        in_valid = 1'b0;
        data_in  = 24'sd0;

        acc_e = 0;
        for (int k = 0; k < 16; k++) acc_e += longint'(hist[k]) * longint'(h0_tab[k]);
        acc_o = 0;
        for (int k = 0; k < 15; k++) acc_o += longint'(hist[k]) * longint'(h1_tab[k]);
        chk("real_even", ev[4], fmt(acc_e));
        chk("real_odd", od[4], fmt(acc_o));
        $display("xact in=%0d even=%0d/%0d odd=%0d/%0d imp=%0d/%0d stall=%0d",
                 x, ev[4], fmt(acc_e), od[4], fmt(acc_o), ev[0], od[0], stall);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = 24'sd0;
        for (int k = 0; k < 16; k++) hist[k] = 24'sd0;
        repeat (3) tick();
        chk("rst_dout", dout[4], 0);
        chk("rst_ov", ov[4], 0);
        chk("rst_ir", ir[4], 1);
        rst_n = 1'b1;
        tick();
        chk("idle_ir", ir[0], 1);
        chk("idle_ov", ov[0], 0);

        // Impulses: tap 0 passes immediately, tap 1 one input later.
        xact(24'sd1000, 0, 1'b0, 1'b0);
        chk("imp_even", ev[0], 1000);
        chk("imp_odd", od[0], 500);
        chk("imp2_even0", ev[1], 0);
        chk("imp2_odd0", od[1], 0);
        xact(24'sd0, 0, 1'b0, 1'b0);
        chk("imp_even_z", ev[0], 0);
        chk("imp_odd_z", od[0], 0);
        chk("imp2_even1", ev[1], 1000);
        xact(24'sd0, 0, 1'b0, 1'b0);
        chk("imp2_even2", ev[1], 0);

        // Rounding: half-up on the gained product.
        xact(24'sd3, 0, 1'b0, 1'b0);
        chk("rnd_p3", ev[2], 2);
        xact(-24'sd3, 0, 1'b0, 1'b0);
        chk("rnd_m3", ev[2], -1);
        chk("imp_odd_m3", od[0], -1);
        xact(24'sd1, 0, 1'b0, 1'b0);
        chk("rnd_p1", ev[2], 1);
        chk("imp_odd_p1", od[0], 1);

        // Saturation at both rails.
        xact(24'sh7FFFFF, 0, 1'b0, 1'b0);
        chk("sat_pos", ev[3], 8388607);
        chk("sat_odd", od[3], 0);
        xact(24'sh800000, 0, 1'b0, 1'b0);
        chk("sat_neg", ev[3], -8388608);
        chk("imp_odd_neg", od[0], -4194304);

        // Reset in the middle of the even MAC phase.
        data_in  = 24'sd777;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data_in  = 24'sd0;
        repeat (5) tick();
        chk("mac_ir_low", ir[0], 0);
        rst_n = 1'b0;
        #1;
        chk("arst_dout", dout[0], 0);
        chk("arst_ov", ov[0], 0);
        chk("arst_ir", ir[0], 1);
        for (int k = 0; k < 16; k++) hist[k] = 24'sd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        xact(24'sd1000, 0, 1'b0, 1'b0);
        chk("post_rst_imp", ev[0], 1000);
        chk("post_rst_hist", ev[1], 0);

        // Backpressure on the even output.
        xact(24'($urandom), 5, 1'b0, 1'b0);
        xact(24'($urandom), 3, 1'b0, 1'b0);

        // Back-to-back with in_valid held high (junk ignored outside IDLE).
        xact(24'($urandom), 0, 1'b1, 1'b0);
        for (int t = 0; t < 10; t++) xact(24'($urandom), 0, 1'b1, 1'b1);
        xact(24'sd0, 0, 1'b1, 1'b1);
        chk("junk_not_shifted", ev[1], longint'(hist[1]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
